int_to_float: RTL and testbench

//  Converts a 32-bit signed two's-complement integer to an IEEE-754 binary32 value.

---
 rtl/float_pkg.sv | 19 +
 rtl/int_to_float.sv | 122 ++++++++++++
 tb/tb_int_to_float.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Shared binary32 constants and the converter state encoding.
// The float adder and the future float_to_int use this package too.
package float_pkg;

  localparam int unsigned F32_FRAC_W = 23;
  localparam int unsigned F32_EXP_W  = 8;
  localparam logic [F32_EXP_W-1:0] F32_BIAS = 8'd127;
  localparam logic [31:0] F32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    GET_A,
    CONVERT,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

endpackage

// File: rtl/int_to_float.sv
// Iterative signed int32 to IEEE-754 binary32 converter, round-to-nearest-even.
// Normalisation shifts one bit per cycle; stb/ack handshakes on input and output.
module int_to_float
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] m_q, m_d;
  logic [31:0] z_q, z_d;
  logic [F32_EXP_W-1:0] e_q, e_d;
  logic [F32_FRAC_W-1:0] frac_q, frac_d;
  logic sign_q, sign_d;
  logic stb_q, stb_d;
  logic ack_q, ack_d;

  // Guard set and (round or sticky or lsb) => round up; bit 23 of the sum is the carry out.
  logic        round_up;
  logic [23:0] frac_sum;
  assign round_up = m_q[7] & (m_q[6] | (|m_q[5:0]) | m_q[8]);
  assign frac_sum = {1'b0, m_q[30:8]} + {23'd0, round_up};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    z_d     = z_q;
    e_d     = e_q;
    frac_d  = frac_q;
    sign_d  = sign_q;
    stb_d   = stb_q;
    ack_d   = ack_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (a_q == 32'd0) begin
          z_d     = F32_ZERO;
          state_d = PUT_Z;
        end else begin
          sign_d  = a_q[31];
          // -2^31 negates to itself, which is the correct unsigned magnitude.
          m_d     = a_q[31] ? (~a_q + 32'd1) : a_q;
          e_d     = 8'd31;
          state_d = NORMALISE;
        end
      end
      NORMALISE: begin
        if (m_q[31]) begin
          state_d = ROUND;
        end else begin
          m_d = {m_q[30:0], 1'b0};
          e_d = e_q - 8'd1;
        end
      end
      ROUND: begin
        frac_d = frac_sum[22:0];
        if (frac_sum[23]) e_d = e_q + 8'd1;
        state_d = PACK;
      end
      PACK: begin
        z_d     = {sign_q, e_q + F32_BIAS, frac_q};
        state_d = PUT_Z;
      end
      PUT_Z: begin
        // stb rises on the first PUT_Z edge; z_q is already stable by then.
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (output_z_ack) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= 32'd0;
      m_q     <= 32'd0;
      z_q     <= F32_ZERO;
      e_q     <= '0;
      frac_q  <= '0;
      sign_q  <= 1'b0;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      z_q     <= z_d;
      e_q     <= e_d;
      frac_q  <= frac_d;
      sign_q  <= sign_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z     = z_q;
  assign output_z_stb = stb_q;

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: vector table, random vs. arithmetic model,
// back-pressure, mid-conversion reset, and a two-converter 3+4 sum.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic        a_stb = 1'b0;
  logic        a_ack;
  logic [31:0] z;
  logic        z_stb;
  logic        z_ack = 1'b0;

  logic [31:0] b_a = '0;
  logic        b_stb = 1'b0;
  logic        b_ack;
  logic [31:0] b_z;
  logic        b_zstb;
  logic        b_zack = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  int_to_float u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (a),
    .input_a_stb  (a_stb),
    .input_a_ack  (a_ack),
    .output_z     (z),
    .output_z_stb (z_stb),
    .output_z_ack (z_ack)
  );

  int_to_float u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (b_a),
    .input_a_stb  (b_stb),
    .input_a_ack  (b_ack),
    .output_z     (b_z),
    .output_z_stb (b_zstb),
    .output_z_ack (b_zack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Index of the most significant set bit of a positive magnitude.
  function automatic int msb_pos(input longint mag);
    int p = 0;
    for (int i = 0; i < 33; i++) if (mag >= (longint'(1) << i)) p = i;
    return p;
  endfunction

  function automatic longint magnitude(input logic [31:0] v);
    longint sv = longint'($signed(v));
    return (sv < 0) ? -sv : sv;
  endfunction

  // Reference: scale the magnitude to 24 significant bits, round half to even.
  function automatic logic [31:0] ref_z(input logic [31:0] v);
    longint mag, q, rem, half;
    int p, ex, sh;
    logic [63:0] qb;
    logic [7:0] eb;
    if (v == 32'd0) return 32'd0;
    mag = magnitude(v);
    p = msb_pos(mag);
    ex = p + 127;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh = p - 23;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        ex = ex + 1;
      end
    end
    qb = 64'(q);
    eb = 8'(ex);
    return {v[31], eb, qb[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] v);
    if (v == 32'd0) return 2;
    return (31 - msb_pos(magnitude(v))) + 5;
  endfunction

  // Wait for input ack, present one operand, return result and edges from accept to stb.
  task automatic convert(input logic [31:0] val, output logic [31:0] res, output int lat);
    int w = 0;
    while (!a_ack && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!a_ack) check("input_ack_timeout", {31'd0, a_ack}, 32'd1);
    a = val;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    lat = 0;
    while (!z_stb && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!z_stb) check("output_stb_timeout", {31'd0, z_stb}, 32'd1);
    res = z;
    z_ack = 1'b1;
    @(posedge clk); #1;
    z_ack = 1'b0;
  endtask

  task automatic convert_b(input logic [31:0] val, output logic [31:0] res);
    int w = 0;
    while (!b_ack && w < 100) begin
      @(posedge clk); #1; w++;
    end
    b_a = val;
    b_stb = 1'b1;
    @(posedge clk); #1;
    b_stb = 1'b0;
    w = 0;
    while (!b_zstb && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!b_zstb) check("b_output_stb_timeout", {31'd0, b_zstb}, 32'd1);
    res = b_z;
    b_zack = 1'b1;
    @(posedge clk); #1;
    b_zack = 1'b0;
  endtask

  function automatic real f32_to_real(input logic [31:0] f);
    real r;
    int ex;
    if (f[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    ex = int'(f[30:23]) - 127;
    for (int i = 0; i < ex; i++) r = r * 2.0;
    for (int i = 0; i > ex; i--) r = r / 2.0;
    return f[31] ? -r : r;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
  } vec_t;

  initial begin
    vec_t vecs[8];
    logic [31:0] res, res_b, val, hold_z;
    int lat, bad;
    real sum;

    vecs[0] = '{32'd1,          32'h3F80_0000, 36};
    vecs[1] = '{32'hFFFF_FFFF,  32'hBF80_0000, 36};
    vecs[2] = '{32'd0,          32'h0000_0000, 2};
    vecs[3] = '{32'h8000_0000,  32'hCF00_0000, 5};
    vecs[4] = '{32'h7FFF_FFFF,  32'h4F00_0000, 6};
    vecs[5] = '{32'd16777217,   32'h4B80_0000, 12};
    vecs[6] = '{32'd16777219,   32'h4B80_0002, 12};
    vecs[7] = '{32'd16777221,   32'h4B80_0002, 12};

    // Reset state
    #2;
    check("reset_ack", {31'd0, a_ack}, 32'd0);
    check("reset_stb", {31'd0, z_stb}, 32'd0);
    check("reset_z", z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ack_after_reset", {31'd0, a_ack}, 32'd1);

    foreach (vecs[i]) begin
      convert(vecs[i].a, res, lat);
      check($sformatf("vec%0d_z", i), res, vecs[i].z);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 150; i++) begin
      val = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) val = ~val + 32'd1;
      if (i == 0) val = 32'd0;
      convert(val, res, lat);
      check($sformatf("rand_z a=%h", val), res, ref_z(val));
      check($sformatf("rand_lat a=%h", val), 32'(lat), 32'(ref_lat(val)));
    end

    // Back-pressure: hold z_ack low for 10 cycles in PUT_Z
    a = 32'd5;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    lat = 0;
    while (!z_stb && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_stb", {31'd0, z_stb}, 32'd1);
    hold_z = z;
    check("bp_z", hold_z, 32'h40A0_0000);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (z !== hold_z || z_stb !== 1'b1 || a_ack !== 1'b0) bad++;
    end
    check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    z_ack = 1'b1;
    @(posedge clk); #1;
    z_ack = 1'b0;
    check("bp_ack_after_handshake", {31'd0, a_ack}, 32'd1);
    check("bp_stb_cleared", {31'd0, z_stb}, 32'd0);
    a = 32'd6;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    check("bp_next_accepted", {31'd0, a_ack}, 32'd0);
    lat = 0;
    while (!z_stb && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_next_z", z, 32'h40C0_0000);
    z_ack = 1'b1;
    @(posedge clk); #1;
    z_ack = 1'b0;

    // Reset during NORMALISE of a=1
    a = 32'd1;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_stb", {31'd0, z_stb}, 32'd0);
    check("midrst_ack", {31'd0, a_ack}, 32'd0);
    check("midrst_z", z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack_after_release", {31'd0, a_ack}, 32'd1);
    convert(32'd3, res, lat);
    check("midrst_next_z", res, 32'h4040_0000);

    // Two converters feeding a sum: 3 + 4 -> 7.0
    fork
      convert(32'd3, res, lat);
      convert_b(32'd4, res_b);
    join
    check("add_op_a", res, 32'h4040_0000);
    check("add_op_b", res_b, 32'h4080_0000);
    sum = f32_to_real(res) + f32_to_real(res_b);
    convert(32'($rtoi(sum)), res, lat);
    check("add_sum_z", res, 32'h40E0_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
